// File: rtl/countdown_timer.sv
// countdown_timer
// MM:SS countdown held as four BCD digits. Decrements once per rising edge
// of the 1 Hz sec_toggle square wave while running, raises alarm for
// ALARM_TICKS seconds on reaching 00:00, then falls back to IDLE.
// Control strobes are prioritised load > pause > start > tick.

module countdown_timer #(
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_toggle,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       alarm,
  output logic       done_pulse,
  output logic       load_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Alarm length as an 8-bit compare value (legal range is 1..255).
  localparam logic [7:0] ALARM_LIMIT = ALARM_TICKS[7:0];

  // True when a single BCD digit does not exceed max_d.
  function automatic logic digit_ok(input logic [3:0] d, input logic [3:0] max_d);
    return (d <= max_d);
  endfunction

  // A preset is loadable only if every digit is decimal and seconds < 60.
  function automatic logic preset_valid(input logic [7:0] mm, input logic [7:0] ss);
    return digit_ok(mm[7:4], 4'd9) && digit_ok(mm[3:0], 4'd9) &&
           digit_ok(ss[7:4], 4'd5) && digit_ok(ss[3:0], 4'd9);
  endfunction

  // One-second BCD decrement of {min_tens, min_units, sec_tens, sec_units}.
  // Seconds units borrow from seconds tens (0 -> 9), seconds tens borrow
  // from minutes (0 -> 5), minutes borrow as a plain two-digit BCD value.
  // Callers never present 00:00, so the minutes tens digit is clamped
  // rather than wrapped.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] d_mt;
    logic [3:0] d_mu;
    logic [3:0] d_st;
    logic [3:0] d_su;
    d_mt = v[15:12];
    d_mu = v[11:8];
    d_st = v[7:4];
    d_su = v[3:0];
    if (d_su != 4'd0) begin
      d_su = d_su - 4'd1;
    end else begin
      d_su = 4'd9;
      if (d_st != 4'd0) begin
        d_st = d_st - 4'd1;
      end else begin
        d_st = 4'd5;
        if (d_mu != 4'd0) begin
          d_mu = d_mu - 4'd1;
        end else begin
          d_mu = 4'd9;
          if (d_mt != 4'd0) begin
            d_mt = d_mt - 4'd1;
          end else begin
            d_mt = 4'd0;
          end
        end
      end
    end
    return {d_mt, d_mu, d_st, d_su};
  endfunction

  state_t      state_r;
  logic        sec_toggle_d_r;
  logic [7:0]  alarm_cnt_r;

  logic        tick_s;
  logic        preset_ok_s;
  logic [15:0] value_s;
  logic [15:0] dec_value_s;
  logic        value_zero_s;
  logic        dec_zero_s;
  logic [7:0]  alarm_cnt_inc_s;
  logic        alarm_last_s;

  // sec_toggle_d_r resets high so a wave already high at reset release
  // does not count as a tick.
  assign tick_s          = sec_toggle & ~sec_toggle_d_r;
  assign preset_ok_s     = preset_valid(preset_min, preset_sec);
  assign value_s         = {min_bcd, sec_bcd};
  assign dec_value_s     = bcd_dec(value_s);
  assign value_zero_s    = (value_s == 16'h0000);
  assign dec_zero_s      = (dec_value_s == 16'h0000);
  assign alarm_cnt_inc_s = alarm_cnt_r + 8'd1;
  assign alarm_last_s    = (alarm_cnt_inc_s == ALARM_LIMIT);

  // Timer FSM: tick edge detect, prioritised control, BCD countdown and
  // alarm timing, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      sec_toggle_d_r <= 1'b1;
      alarm_cnt_r    <= 8'd0;
      min_bcd        <= 8'h00;
      sec_bcd        <= 8'h00;
      running        <= 1'b0;
      alarm          <= 1'b0;
      done_pulse     <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      sec_toggle_d_r <= sec_toggle;
      done_pulse     <= 1'b0;
      load_err       <= 1'b0;

      if (load && (state_r != ST_RUN)) begin
        // A load outside RUN consumes the cycle whether it is accepted or not.
        if (preset_ok_s) begin
          min_bcd     <= preset_min;
          sec_bcd     <= preset_sec;
          state_r     <= ST_IDLE;
          running     <= 1'b0;
          alarm       <= 1'b0;
          alarm_cnt_r <= 8'd0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (pause && (state_r == ST_RUN)) begin
        state_r <= ST_PAUSE;
        running <= 1'b0;
      end else if (start && ((state_r == ST_IDLE) || (state_r == ST_PAUSE)) && !value_zero_s) begin
        state_r <= ST_RUN;
        running <= 1'b1;
      end else if (tick_s) begin
        case (state_r)
          ST_RUN: begin
            min_bcd <= dec_value_s[15:8];
            sec_bcd <= dec_value_s[7:0];
            if (dec_zero_s) begin
              state_r     <= ST_DONE;
              running     <= 1'b0;
              alarm       <= 1'b1;
              alarm_cnt_r <= 8'd0;
              done_pulse  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_DONE: begin
            alarm_cnt_r <= alarm_cnt_inc_s;
            if (alarm_last_s) begin
              state_r <= ST_IDLE;
              alarm   <= 1'b0;
            end else begin
              state_r <= ST_DONE;
            end
          end
          default: begin
            // Ticks are ignored while idle or paused.
            state_r <= state_r;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Scoreboard bench: the driver applies one stimulus vector per clock and
// pushes the outputs a time-in-seconds reference model predicts for that
// edge; an independent monitor pops and compares after each edge.

module tb_countdown_timer;

  localparam int ALARM = 5;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_toggle = 1'b1;
  logic       load = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       alarm;
  logic       done_pulse;
  logic       load_err;

  countdown_timer #(.ALARM_TICKS(ALARM)) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_toggle (sec_toggle),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .start      (start),
    .pause      (pause),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .running    (running),
    .alarm      (alarm),
    .done_pulse (done_pulse),
    .load_err   (load_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [19:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: remaining time in whole seconds plus a mode.
  int m_secs = 0;
  int m_mode = M_IDLE;
  int m_alarm_left = 0;
  bit m_prev_tog = 1'b1;

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b / 16) * 10 + int'(b % 16);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic bit valid_time(input logic [7:0] pm, input logic [7:0] ps);
    return ((pm / 16) <= 9) && ((pm % 16) <= 9) && ((ps / 16) <= 5) && ((ps % 16) <= 9);
  endfunction

  task automatic model_step(input bit ld, input logic [7:0] pm, input logic [7:0] ps,
                            input bit st, input bit pa, input bit tog,
                            output logic [19:0] e);
    bit tick;
    bit dp;
    bit le;
    tick = tog && !m_prev_tog;
    m_prev_tog = tog;
    dp = 1'b0;
    le = 1'b0;
    if (ld && m_mode != M_RUN) begin
      if (valid_time(pm, ps)) begin
        m_secs = bcd_val(pm) * 60 + bcd_val(ps);
        m_mode = M_IDLE;
        m_alarm_left = 0;
      end else begin
        le = 1'b1;
      end
    end else if (pa && m_mode == M_RUN) begin
      m_mode = M_PAUSE;
    end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs > 0) begin
      m_mode = M_RUN;
    end else if (tick) begin
      if (m_mode == M_RUN) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_DONE;
          m_alarm_left = ALARM;
          dp = 1'b1;
        end
      end else if (m_mode == M_DONE) begin
        m_alarm_left = m_alarm_left - 1;
        if (m_alarm_left == 0) m_mode = M_IDLE;
      end
    end
    e = {to_bcd(m_secs / 60), to_bcd(m_secs % 60), (m_mode == M_RUN), (m_mode == M_DONE), dp, le};
  endtask

  // Drive one cycle of stimulus and queue the prediction for the next edge.
  task automatic step(input bit ld, input logic [7:0] pm, input logic [7:0] ps,
                      input bit st, input bit pa, input bit tog);
    exp_t        ent;
    logic [19:0] ex;
    @(posedge clk);
    #1;
    load = ld;
    preset_min = pm;
    preset_sec = ps;
    start = st;
    pause = pa;
    sec_toggle = tog;
    model_step(ld, pm, ps, st, pa, tog, ex);
    ent.tgt = cyc + 1;
    ent.exp = ex;
    sbq.push_back(ent);
  endtask

  task automatic idle();
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, sec_toggle);
  endtask

  task automatic tick_pulse();
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, 1'b1);
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] pm, input logic [7:0] ps);
    step(1'b1, pm, ps, 1'b0, 1'b0, sec_toggle);
  endtask

  task automatic do_start();
    step(1'b0, preset_min, preset_sec, 1'b1, 1'b0, sec_toggle);
  endtask

  task automatic do_pause();
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b1, sec_toggle);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({min_bcd, sec_bcd, running, alarm, done_pulse, load_err} !== 20'd0) begin
      errors++;
      $display("FAIL %s: got outputs %h, expected 00000", tag,
               {min_bcd, sec_bcd, running, alarm, done_pulse, load_err});
    end
  endtask

  // Asynchronous reset in the middle of a cycle, sec_toggle held high.
  task automatic mid_reset();
    @(posedge clk);
    #7;
    rst = 1'b1;
    load = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    sec_toggle = 1'b1;
    #1;
    check_zero("async_reset");
    sbq.delete();
    m_secs = 0;
    m_mode = M_IDLE;
    m_alarm_left = 0;
    m_prev_tog = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare every prediction whose edge has passed.
  initial begin
    exp_t        ent;
    logic [19:0] got;
    forever begin
      @(posedge clk);
      #5;
      while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
        ent = sbq.pop_front();
        got = {min_bcd, sec_bcd, running, alarm, done_pulse, load_err};
        checks++;
        if (got !== ent.exp) begin
          errors++;
          $display("FAIL cycle %0d outputs: got min=%h sec=%h run=%b alarm=%b done=%b lerr=%b, expected min=%h sec=%h run=%b alarm=%b done=%b lerr=%b",
                   cyc, got[19:12], got[11:4], got[3], got[2], got[1], got[0],
                   ent.exp[19:12], ent.exp[11:4], ent.exp[3], ent.exp[2], ent.exp[1], ent.exp[0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int          half;
    bit          t;
    bit          ld;
    bit          st;
    bit          pa;
    logic [7:0]  pm;
    logic [7:0]  ps;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_init");
    rst = 1'b0;

    // Count down 01:05 through the minute borrow.
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    do_load(8'h01, 8'h05);
    do_start();
    repeat (6) tick_pulse();

    // Reach 00:00, alarm for ALARM ticks, back to IDLE.
    do_pause();
    do_load(8'h00, 8'h02);
    do_start();
    repeat (2) tick_pulse();
    repeat (2) idle();
    repeat (ALARM) tick_pulse();
    idle();

    // Pause coinciding with a tick from 10:00, then resume.
    do_load(8'h10, 8'h00);
    do_start();
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b1, 1'b1);
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, 1'b0);
    do_start();
    tick_pulse();

    // Invalid loads while paused, then a load ignored during RUN.
    do_pause();
    do_load(8'h00, 8'h60);
    do_load(8'h1A, 8'h00);
    do_start();
    do_load(8'h04, 8'h00);
    tick_pulse();

    // Start with 00:00 loaded does nothing.
    do_pause();
    do_load(8'h00, 8'h00);
    do_start();
    repeat (2) idle();
    tick_pulse();

    // Reset mid-run at 05:30 with sec_toggle high.
    do_load(8'h05, 8'h31);
    do_start();
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, 1'b1);
    mid_reset();
    do_load(8'h00, 8'h03);
    do_start();
    repeat (4) idle();
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, 1'b0);
    step(1'b0, preset_min, preset_sec, 1'b0, 1'b0, 1'b1);
    idle();

    // Randomized traffic.
    half = 2;
    for (int i = 0; i < 3000; i++) begin
      t = sec_toggle;
      if (half == 0) begin
        t = !t;
        half = $urandom_range(1, 4);
      end else begin
        half = half - 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        pm = 8'($urandom);
        ps = 8'($urandom);
      end else begin
        pm = {4'h0, 4'($urandom_range(0, 1))};
        ps = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      end
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 19) == 0);
      step(ld, pm, ps, st, pa, t);
    end

    repeat (3) idle();
    repeat (2) @(posedge clk);
    #8;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes:seconds countdown timer that consumes the 1 Hz square wave produced by the 1-second counter stage and decrements a two-digit-minute, two-digit-second BCD value once per second. Software or button logic loads a preset, starts, and pauses it. On reaching 00:00 it raises an alarm for a programmable number of seconds. BCD outputs feed the seven-segment display driver directly.

## Interface
- ALARM_TICKS, default 5: number of 1 s ticks the alarm stays high after reaching 00:00 (1..255).
- clk  in  1  system clock, 50 MHz (20 ns).
- rst  in  1  asynchronous, active-high reset.
- sec_toggle  in  1  1 Hz square wave from the 1-second counter, synchronous to clk; each rising edge is one tick.
- load  in  1  one-cycle strobe: load preset_min/preset_sec.
- preset_min  in  8  BCD minutes, {tens, units}, 00..99.
- preset_sec  in  8  BCD seconds, {tens, units}, 00..59.
- start  in  1  one-cycle strobe: begin or resume counting.
- pause  in  1  one-cycle strobe: hold the count.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- running  out  1  high in RUN state.
- alarm  out  1  high during the alarm period.
- done_pulse  out  1  one-cycle pulse when the count reaches 00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Tick detect: register sec_toggle_d; tick = sec_toggle & ~sec_toggle_d. sec_toggle_d resets to 1, so a high input at reset release produces no tick.
- States:
  - IDLE: holds the value; not counting.
  - RUN: counting down.
  - PAUSE: count held.
  - DONE: alarm active.
- Priority within one cycle: load > pause > start > tick.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN with no load_err.
  - Validity: every nibble ≤ 9 and the preset_sec tens digit ≤ 5.
  - Valid load: copies the preset, goes to IDLE, clears alarm and the alarm count.
  - Invalid load: value and state are unchanged; load_err pulses.
- Start:
  - IDLE or PAUSE with a nonzero value goes to RUN.
  - Value 00:00: start is ignored.
  - Start in RUN or DONE: ignored.
- Pause: RUN goes to PAUSE. Ignored in every other state.
- Decrement on tick in RUN, BCD with borrow:
  - Seconds units 0 becomes 9 and borrows from seconds tens.
  - Seconds tens 0 becomes 5 and borrows from minutes.
  - Minutes decrement as two BCD digits; 10:00 becomes 09:59.
- Reaching 00:00 (the tick that turns 00:01 into 00:00):
  - Same edge: state goes to DONE, alarm goes to 1, alarm count clears to 0.
  - done_pulse goes high for exactly the following cycle.
- DONE:
  - Each tick increments the alarm count.
  - When the count reaches ALARM_TICKS, state goes to IDLE and alarm goes to 0; the value stays at 00:00.
  - A tick in IDLE or PAUSE is ignored.
- No wrap-around: the count never goes below 00:00.

## Timing
- Reset values: min_bcd=8'h00, sec_bcd=8'h00, running=0, alarm=0, done_pulse=0, load_err=0, state IDLE, sec_toggle_d=1.
- Reset is asynchronous and takes effect mid-run immediately. After release the block waits in IDLE for a load.
- All outputs are registered.
- Tick latency: for a sec_toggle rising edge first sampled at clock edge k, the new value is visible after edge k (one cycle).
- load, start and pause are sampled every cycle. Their effect is visible after the same edge; load_err is likewise visible after that edge.
- Simultaneous events:
  - tick + pause in RUN: PAUSE with no decrement.
  - tick + load in DONE: the load wins and the alarm count is not incremented.
- A start held high across multiple cycles acts like a single start. A pause in the cycle after start returns to PAUSE.

## Test plan
- Reset, then load 01:05 and start. Issue 6 ticks: after tick 5 the value is 01:00; after tick 6 it is 00:59, with running=1 throughout.
- Load 00:02, start, issue 2 ticks: the value is 00:00, state DONE, alarm=1, done_pulse high for exactly one cycle. After 5 more ticks alarm=0, state IDLE.
- Run from 10:00 and apply pause on the same cycle as a tick: the value stays 10:00 and running=0. Start again; the next tick gives 09:59.
- Load preset_sec=8'h60, then preset_min=8'h1A: each gives a load_err pulse and leaves the value unchanged. A load during RUN is ignored without load_err.
- Start with 00:00 loaded: stays IDLE, running=0, no done_pulse.
- Assert rst mid-run at 05:30 with sec_toggle=1: outputs are 0 immediately. After release, no tick is generated until sec_toggle falls and rises again.
